// File: rtl/stack_sequencer_if.sv
// -----------------------------------------------------------------------------
// stack_sequencer_if
//
// Bundle of every non-clock/non-reset signal of stack_sequencer.
//
// Handshakes:
//   op_valid/op_ready : an op transfers on the rising edge where both are 1.
//     The requester holds op_valid, op_code, push_pc and push_flags stable
//     until that edge. op_valid seen while op_ready is 0 is ignored, not queued.
//   mem_req/mem_gnt   : an access completes on the rising edge where both are
//     1. mem_we, mem_addr and mem_wdata stay stable from the first cycle of
//     mem_req until that edge. Read data is returned on mem_rdata in the cycle
//     after a granted read.
//
// Signal groups:
//   op side    : op_valid, op_code, op_ready, push_pc, push_flags
//   memory side: mem_req, mem_we, mem_addr, mem_wdata, mem_gnt, mem_rdata
//   results    : stall, sp, pc_out, pc_valid, flags_out, flags_valid, done
//   debug      : dbg_state (FSM state encoding), dbg_index (word index)
//
// Modports:
//   slave  : the sequencer itself
//   master : the environment that issues ops and serves memory
// -----------------------------------------------------------------------------
interface stack_sequencer_if;
  logic        op_valid;
  logic [1:0]  op_code;
  logic        op_ready;
  logic [31:0] push_pc;
  logic [2:0]  push_flags;

  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [15:0] mem_wdata;
  logic        mem_gnt;
  logic [15:0] mem_rdata;

  logic        stall;
  logic [31:0] sp;
  logic [31:0] pc_out;
  logic        pc_valid;
  logic [2:0]  flags_out;
  logic        flags_valid;
  logic        done;

  logic [2:0]  dbg_state;
  logic [1:0]  dbg_index;

  modport slave (
    input  op_valid, op_code, push_pc, push_flags, mem_gnt, mem_rdata,
    output op_ready, mem_req, mem_we, mem_addr, mem_wdata,
           stall, sp, pc_out, pc_valid, flags_out, flags_valid, done,
           dbg_state, dbg_index
  );

  modport master (
    output op_valid, op_code, push_pc, push_flags, mem_gnt, mem_rdata,
    input  op_ready, mem_req, mem_we, mem_addr, mem_wdata,
           stall, sp, pc_out, pc_valid, flags_out, flags_valid, done,
           dbg_state, dbg_index
  );
endinterface

// File: rtl/stack_sequencer.sv
// -----------------------------------------------------------------------------
// stack_sequencer
//
// Multi-cycle controller that runs CALL / RET / INT / RTI stack traffic over a
// single 16-bit data-memory port. It owns the 32-bit stack pointer, splits
// each 32-bit PC into two 16-bit words, pushes/pops a 3-bit flag word for
// interrupts, stalls the front of the pipeline while busy, and hands the
// popped PC and flags back to fetch and the flag register.
//
// Stack discipline: SP points at the next free word. A push writes at SP and
// then decrements; a pop reads at SP+1 and then increments. All SP arithmetic
// wraps modulo 2^32.
//
// Ports:
//   clk   in  rising-edge clock
//   reset in  asynchronous, active-low reset
//   bus   slave modport of stack_sequencer_if (op handshake, memory port,
//         stall/sp/popped results, debug state)
//
// Op codes: 00 CALL, 01 RET, 10 INT, 11 RTI. Bit 0 set means a pop op.
//
// Word order on the stack:
//   CALL push : PC[31:16], PC[15:0]
//   INT  push : PC[31:16], PC[15:0], {13'b0, flags}
//   RET  pop  : PC[15:0], PC[31:16]
//   RTI  pop  : flags, PC[15:0], PC[31:16]
// -----------------------------------------------------------------------------
module stack_sequencer #(
  parameter logic [31:0] SP_RESET = 32'h0000_0FFF
) (
  input  logic               clk,
  input  logic               reset,
  stack_sequencer_if.slave   bus
);

  localparam logic [1:0] OP_CALL = 2'b00;
  localparam logic [1:0] OP_RET  = 2'b01;
  localparam logic [1:0] OP_INT  = 2'b10;
  localparam logic [1:0] OP_RTI  = 2'b11;

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_PUSH     = 3'd1,
    S_POP_REQ  = 3'd2,
    S_POP_WAIT = 3'd3,
    S_DONE     = 3'd4
  } state_t;

  state_t      state;
  state_t      next_state;

  // Latched op context, held for the whole sequence.
  logic [1:0]  op_q;
  logic [31:0] pc_q;
  logic [2:0]  flags_q;
  logic [1:0]  idx;

  logic [31:0] sp_q;
  logic [31:0] pc_out_q;
  logic [2:0]  flags_out_q;
  logic        done_q;
  logic        pc_valid_q;
  logic        flags_valid_q;

  logic        accept;
  logic        last_word;
  logic [1:0]  last_idx;
  logic [15:0] push_word;
  logic [1:0]  pop_slot;
  logic [31:0] sp_plus_one;

  assign accept      = bus.op_valid && (state == S_IDLE);
  assign sp_plus_one = sp_q + 32'd1;

  // CALL and RET move two words; INT and RTI move three.
  assign last_idx  = ((op_q == OP_CALL) || (op_q == OP_RET)) ? 2'd1 : 2'd2;
  assign last_word = (idx == last_idx);

  // Push word selected by index. The same order serves CALL and INT; CALL
  // simply never reaches index 2.
  always_comb begin
    push_word = 16'h0000;
    case (idx)
      2'd0:    push_word = pc_q[31:16];
      2'd1:    push_word = pc_q[15:0];
      default: push_word = {13'b0, flags_q};
    endcase
  end

  // Destination of a popped word: 0 = flags, 1 = PC low, 2 = PC high.
  // RTI pops flags first, so its index maps straight through; RET starts at
  // the PC low half, one slot further on.
  assign pop_slot = (op_q == OP_RTI) ? idx : (idx + 2'd1);

  // ---------------------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= S_IDLE;
    end else begin
      state <= next_state;
    end
  end

  // ---------------------------------------------------------------------------
  // FSM: next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    next_state = state;
    case (state)
      S_IDLE: begin
        if (accept) begin
          next_state = bus.op_code[0] ? S_POP_REQ : S_PUSH;
        end
      end
      S_PUSH: begin
        if (bus.mem_gnt && last_word) begin
          next_state = S_DONE;
        end
      end
      S_POP_REQ: begin
        if (bus.mem_gnt) begin
          next_state = S_POP_WAIT;
        end
      end
      S_POP_WAIT: begin
        next_state = last_word ? S_DONE : S_POP_REQ;
      end
      S_DONE: begin
        next_state = S_IDLE;
      end
      default: begin
        next_state = S_IDLE;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // FSM: outputs decoded from the current state. Because addr/we/wdata depend
  // only on registered state, SP and index, a request stays stable until its
  // grant edge.
  // ---------------------------------------------------------------------------
  always_comb begin
    bus.op_ready  = 1'b0;
    bus.stall     = 1'b1;
    bus.mem_req   = 1'b0;
    bus.mem_we    = 1'b0;
    bus.mem_addr  = sp_q;
    bus.mem_wdata = 16'h0000;
    case (state)
      S_IDLE: begin
        bus.op_ready = 1'b1;
        bus.stall    = 1'b0;
      end
      S_PUSH: begin
        bus.mem_req   = 1'b1;
        bus.mem_we    = 1'b1;
        bus.mem_wdata = push_word;
      end
      S_POP_REQ: begin
        bus.mem_req  = 1'b1;
        bus.mem_addr = sp_plus_one;
      end
      default: begin
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Datapath: op context, stack pointer, popped results and status pulses.
  // An asynchronous reset mid-op drops the sequence and restores SP; words
  // already pushed remain in memory.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      op_q          <= OP_CALL;
      pc_q          <= 32'h0;
      flags_q       <= 3'b0;
      idx           <= 2'd0;
      sp_q          <= SP_RESET;
      pc_out_q      <= 32'h0;
      flags_out_q   <= 3'b0;
      done_q        <= 1'b0;
      pc_valid_q    <= 1'b0;
      flags_valid_q <= 1'b0;
    end else begin
      // Pulses are registered so they are high exactly while in DONE.
      done_q        <= (next_state == S_DONE);
      pc_valid_q    <= (next_state == S_DONE) && op_q[0];
      flags_valid_q <= (next_state == S_DONE) && (op_q == OP_RTI);

      case (state)
        S_IDLE: begin
          if (accept) begin
            op_q    <= bus.op_code;
            pc_q    <= bus.push_pc;
            flags_q <= bus.push_flags;
            idx     <= 2'd0;
          end
        end
        S_PUSH: begin
          if (bus.mem_gnt) begin
            sp_q <= sp_q - 32'd1;
            idx  <= idx + 2'd1;
          end
        end
        S_POP_REQ: begin
          if (bus.mem_gnt) begin
            sp_q <= sp_plus_one;
          end
        end
        S_POP_WAIT: begin
          case (pop_slot)
            2'd0:    flags_out_q     <= bus.mem_rdata[2:0];
            2'd1:    pc_out_q[15:0]  <= bus.mem_rdata;
            default: pc_out_q[31:16] <= bus.mem_rdata;
          endcase
          idx <= idx + 2'd1;
        end
        default: begin
        end
      endcase
    end
  end

  assign bus.sp          = sp_q;
  assign bus.pc_out      = pc_out_q;
  assign bus.flags_out   = flags_out_q;
  assign bus.done        = done_q;
  assign bus.pc_valid    = pc_valid_q;
  assign bus.flags_valid = flags_valid_q;
  assign bus.dbg_state   = state;
  assign bus.dbg_index   = idx;

endmodule

// File: tb/tb_stack_sequencer.sv
// -----------------------------------------------------------------------------
// tb_stack_sequencer
//
// Two sequencers share one clock, reset and memory: dut0 starts at SP=0FFF,
// dut1 starts at SP=0 for the address-wrap case. A tb-level select routes op
// requests to one of them and muxes its outputs into a common view.
// -----------------------------------------------------------------------------
module tb_stack_sequencer;

  logic clk;
  logic reset_n;

  stack_sequencer_if if0 ();
  stack_sequencer_if if1 ();

  stack_sequencer #(.SP_RESET(32'h0000_0FFF)) dut0 (
    .clk   (clk),
    .reset (reset_n),
    .bus   (if0.slave)
  );

  stack_sequencer #(.SP_RESET(32'h0000_0000)) dut1 (
    .clk   (clk),
    .reset (reset_n),
    .bus   (if1.slave)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- stimulus signals ----------------
  logic        sel;
  logic        op_valid;
  logic [1:0]  op_code;
  logic [31:0] push_pc;
  logic [2:0]  push_flags;
  logic        mem_gnt;
  logic [15:0] mem_rdata;
  logic [15:0] rd_buf;

  assign if0.op_valid   = op_valid && !sel;
  assign if1.op_valid   = op_valid && sel;
  assign if0.op_code    = op_code;
  assign if1.op_code    = op_code;
  assign if0.push_pc    = push_pc;
  assign if1.push_pc    = push_pc;
  assign if0.push_flags = push_flags;
  assign if1.push_flags = push_flags;
  assign if0.mem_gnt    = mem_gnt;
  assign if1.mem_gnt    = mem_gnt;
  assign if0.mem_rdata  = mem_rdata;
  assign if1.mem_rdata  = mem_rdata;

  // ---------------- muxed view of the selected DUT ----------------
  logic        m_req, m_we, m_stall, m_ready, m_done, m_pcv, m_flv;
  logic [31:0] m_addr, m_sp, m_pc;
  logic [15:0] m_wdata;
  logic [2:0]  m_flags, m_state;

  assign m_req   = sel ? if1.mem_req     : if0.mem_req;
  assign m_we    = sel ? if1.mem_we      : if0.mem_we;
  assign m_addr  = sel ? if1.mem_addr    : if0.mem_addr;
  assign m_wdata = sel ? if1.mem_wdata   : if0.mem_wdata;
  assign m_stall = sel ? if1.stall       : if0.stall;
  assign m_ready = sel ? if1.op_ready    : if0.op_ready;
  assign m_done  = sel ? if1.done        : if0.done;
  assign m_pcv   = sel ? if1.pc_valid    : if0.pc_valid;
  assign m_flv   = sel ? if1.flags_valid : if0.flags_valid;
  assign m_sp    = sel ? if1.sp          : if0.sp;
  assign m_pc    = sel ? if1.pc_out      : if0.pc_out;
  assign m_flags = sel ? if1.flags_out   : if0.flags_out;
  assign m_state = sel ? if1.dbg_state   : if0.dbg_state;

  // ---------------- scoreboard ----------------
  int passed = 0;
  int total  = 0;
  logic [47:0] exp_wr_q[$];   // {addr, wdata} of expected writes, in order
  logic [31:0] exp_rd_q[$];   // addresses of expected reads, in order
  logic [31:0] model_sp[2];
  logic [15:0] mem [logic [31:0]];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  task automatic fail_now(input string name);
    total++;
    $display("FAIL %s at %0t", name, $time);
  endtask

  // Memory model and access checker; runs after the driver's mid-cycle update.
  always @(negedge clk) begin
    #2;
    if (reset_n && m_req && mem_gnt) begin
      if (m_we) begin
        if (exp_wr_q.size() == 0) fail_now("unexpected_write");
        else check("mem_write", {m_addr, m_wdata}, exp_wr_q.pop_front());
        mem[m_addr] = m_wdata;
      end else begin
        if (exp_rd_q.size() == 0) fail_now("unexpected_read");
        else check("mem_read_addr", m_addr, exp_rd_q.pop_front());
        rd_buf = mem.exists(m_addr) ? mem[m_addr] : 16'h0000;
      end
    end
  end

  always @(posedge clk) mem_rdata <= rd_buf;

  // ---------------- vector table ----------------
  typedef struct {
    bit          sel;
    logic [1:0]  op;
    logic [31:0] pc;
    logic [2:0]  flags;
    int          gnt_delay;
    int          lat;
    logic [31:0] sp;
    logic [31:0] pc_exp;
    logic [2:0]  flags_exp;
  } vec_t;

  function automatic vec_t mk(bit s, logic [1:0] op, logic [31:0] pc, logic [2:0] fl,
                              int d, int lat, logic [31:0] sp, logic [31:0] pce,
                              logic [2:0] fle);
    vec_t v;
    v.sel = s; v.op = op; v.pc = pc; v.flags = fl; v.gnt_delay = d;
    v.lat = lat; v.sp = sp; v.pc_exp = pce; v.flags_exp = fle;
    return v;
  endfunction

  // ---------------- driver ----------------
  task automatic run_op(input vec_t v, input int id);
    int          lat;
    int          nwords;
    logic        busy_ok, held_ok;
    logic [31:0] a0;
    logic [15:0] w0;
    logic        we0;
    logic [15:0] words[3];
    string       tag;
    tag = $sformatf("v%0d", id);

    // Expected memory traffic from a simple SP model.
    nwords = (v.op == 2'b00 || v.op == 2'b01) ? 2 : 3;
    words[0] = v.pc[31:16];
    words[1] = v.pc[15:0];
    words[2] = {13'b0, v.flags};
    for (int w = 0; w < nwords; w++) begin
      if (!v.op[0]) begin
        exp_wr_q.push_back({model_sp[v.sel], words[w]});
        model_sp[v.sel] = model_sp[v.sel] - 32'd1;
      end else begin
        model_sp[v.sel] = model_sp[v.sel] + 32'd1;
        exp_rd_q.push_back(model_sp[v.sel]);
      end
    end

    @(negedge clk); #1;
    sel = v.sel;
    #1;
    check({tag, "_ready_before"}, {m_ready, m_stall}, 2'b10);
    op_code = v.op; push_pc = v.pc; push_flags = v.flags;
    mem_gnt = 1'b1; op_valid = 1'b1;
    @(posedge clk); #1;
    op_valid = 1'b0;
    push_pc = 32'h0; push_flags = 3'b0;

    lat = 0; busy_ok = 1'b1; held_ok = 1'b1;
    a0 = 32'h0; w0 = 16'h0; we0 = 1'b0;
    for (int cyc = 1; cyc <= 40; cyc++) begin
      @(negedge clk); #1;
      if (m_done) begin
        lat = cyc;
        check({tag, "_valid_pulses"}, {m_pcv, m_flv}, {v.op[0], v.op == 2'b11});
        break;
      end
      if (!m_stall) busy_ok = 1'b0;
      if (cyc == 1) begin
        a0 = m_addr; w0 = m_wdata; we0 = m_we;
      end else if (cyc <= v.gnt_delay) begin
        if (m_addr !== a0 || m_wdata !== w0 || m_we !== we0 || m_req !== 1'b1) held_ok = 1'b0;
      end
      mem_gnt = (cyc > v.gnt_delay);
    end
    mem_gnt = 1'b1;
    if (lat == 0) fail_now({tag, "_done_timeout"});
    check({tag, "_latency"}, lat, v.lat);
    check({tag, "_stall_busy"}, busy_ok, 1'b1);
    if (v.gnt_delay > 0) check({tag, "_req_held"}, held_ok, 1'b1);
    check({tag, "_sp"}, m_sp, v.sp);
    if (v.op[0]) check({tag, "_pc_out"}, m_pc, v.pc_exp);
    if (v.op == 2'b11) check({tag, "_flags_out"}, m_flags, v.flags_exp);

    @(negedge clk); #1;
    check({tag, "_idle_after"}, {m_ready, m_stall, m_done, m_pcv, m_flv}, 5'b10000);
  endtask

  vec_t vecs[12];

  initial begin
    #200000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    sel = 1'b0; op_valid = 1'b0; op_code = 2'b00; push_pc = 32'h0; push_flags = 3'b0;
    mem_gnt = 1'b0; rd_buf = 16'h0; mem_rdata = 16'h0;
    model_sp[0] = 32'h0000_0FFF;
    model_sp[1] = 32'h0000_0000;

    //            sel op     pc            fl      dly lat sp             pc_exp        fl_exp
    vecs[0]  = mk(0, 2'b00, 32'h0001_2345, 3'b000, 0, 3, 32'h0000_0FFD, 32'h0,        3'b000);
    vecs[1]  = mk(0, 2'b01, 32'h0,         3'b000, 0, 5, 32'h0000_0FFF, 32'h0001_2345, 3'b000);
    vecs[2]  = mk(0, 2'b10, 32'h0000_00A0, 3'b101, 0, 4, 32'h0000_0FFC, 32'h0,        3'b000);
    vecs[3]  = mk(0, 2'b11, 32'h0,         3'b000, 0, 7, 32'h0000_0FFF, 32'h0000_00A0, 3'b101);
    vecs[4]  = mk(0, 2'b00, 32'hDEAD_BEEF, 3'b000, 0, 3, 32'h0000_0FFD, 32'h0,        3'b000);
    vecs[5]  = mk(0, 2'b10, 32'h1234_5678, 3'b010, 0, 4, 32'h0000_0FFA, 32'h0,        3'b000);
    vecs[6]  = mk(0, 2'b11, 32'h0,         3'b000, 0, 7, 32'h0000_0FFD, 32'h1234_5678, 3'b010);
    vecs[7]  = mk(0, 2'b01, 32'h0,         3'b000, 0, 5, 32'h0000_0FFF, 32'hDEAD_BEEF, 3'b000);
    vecs[8]  = mk(0, 2'b00, 32'h0001_2345, 3'b000, 3, 6, 32'h0000_0FFD, 32'h0,        3'b000);
    vecs[9]  = mk(0, 2'b01, 32'h0,         3'b000, 2, 7, 32'h0000_0FFF, 32'h0001_2345, 3'b000);
    vecs[10] = mk(1, 2'b00, 32'hCAFE_0001, 3'b000, 0, 3, 32'hFFFF_FFFE, 32'h0,        3'b000);
    vecs[11] = mk(1, 2'b01, 32'h0,         3'b000, 0, 5, 32'h0000_0000, 32'hCAFE_0001, 3'b000);

    // Reset state.
    reset_n = 1'b0;
    @(negedge clk); @(negedge clk); #1;
    check("rst_ctrl", {m_ready, m_stall, m_req, m_we, m_done, m_pcv, m_flv}, 7'b1000000);
    check("rst_mem_addr", m_addr, 32'h0000_0FFF);
    check("rst_mem_wdata", m_wdata, 16'h0000);
    check("rst_sp", m_sp, 32'h0000_0FFF);
    check("rst_pc_flags", {m_pc, m_flags}, 35'h0);
    check("rst_state", m_state, 3'd0);
    check("rst_sp_dut1", if1.sp, 32'h0000_0000);
    reset_n = 1'b1;

    for (int i = 0; i < 12; i++) run_op(vecs[i], i);

    // Reset during the second push word of an INT aborts immediately.
    sel = 1'b0;
    exp_wr_q.push_back({32'h0000_0FFF, 16'hABCD});
    @(negedge clk); #1;
    op_code = 2'b10; push_pc = 32'hABCD_1234; push_flags = 3'b011;
    mem_gnt = 1'b1; op_valid = 1'b1;
    @(posedge clk); #1;
    op_valid = 1'b0;
    @(negedge clk); #1;
    check("abort_cycle1_state", m_state, 3'd1);
    @(negedge clk); #1;
    check("abort_cycle2_req", {m_state, m_addr, m_wdata}, {3'd1, 32'h0000_0FFE, 16'h1234});
    reset_n = 1'b0;
    #1;
    check("abort_state", m_state, 3'd0);
    check("abort_sp", m_sp, 32'h0000_0FFF);
    check("abort_ctrl", {m_req, m_stall, m_done, m_ready}, 4'b0001);
    @(negedge clk); #1;
    check("abort_no_done", m_done, 1'b0);
    reset_n = 1'b1;
    model_sp[0] = 32'h0000_0FFF;
    model_sp[1] = 32'h0000_0000;
    @(negedge clk); #1;
    check("abort_after_release", {m_state, m_done, m_stall}, 5'b00000);
    check("abort_dut1_sp", if1.sp, 32'h0000_0000);

    // Normal operation resumes after the abort.
    run_op(mk(0, 2'b00, 32'h0BAD_F00D, 3'b000, 0, 3, 32'h0000_0FFD, 32'h0, 3'b000), 12);
    run_op(mk(0, 2'b01, 32'h0,         3'b000, 0, 5, 32'h0000_0FFF, 32'h0BAD_F00D, 3'b000), 13);

    check("wr_queue_drained", exp_wr_q.size(), 0);
    check("rd_queue_drained", exp_rd_q.size(), 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/stack_sequencer.md
# stack_sequencer

Multi-cycle controller that sequences stack traffic for CALL, RET, INT and RTI through the single 16-bit data-memory port. It sits alongside the execute/memory stages. It owns the 32-bit stack pointer and splits each 32-bit PC transfer into two 16-bit words, pushing or popping the 3-bit flag word for interrupts. It stalls the front of the pipeline until the sequence completes and returns the popped PC and flags to the fetch stage and the flag register.

## Interface
- SP_RESET, 32'h0000_0FFF, stack-pointer value after reset
- clk  in  1  clock; all state updates on rising edge
- reset  in  1  asynchronous, active-low reset
- op_valid  in  1  stack operation requested; held by upstream until accepted
- op_code  in  2  00 CALL, 01 RET, 10 INT, 11 RTI
- op_ready  out  1  high only in IDLE; accept on edge where op_valid & op_ready
- push_pc  in  32  PC to save; sampled at accept
- push_flags  in  3  {C,N,Z} to save; sampled at accept
- mem_req  out  1  memory access request
- mem_we  out  1  1 = write, 0 = read; valid while mem_req
- mem_addr  out  32  access address
- mem_wdata  out  16  write data
- mem_gnt  in  1  port granted this cycle; access completes at this edge
- mem_rdata  in  16  read data, valid the cycle after a granted read
- stall  out  1  high whenever state ≠ IDLE
- sp  out  32  current stack pointer
- pc_out  out  32  popped PC, registered, holds until next pop
- pc_valid  out  1  one-cycle pulse in DONE after RET/RTI
- flags_out  out  3  popped flags, registered
- flags_valid  out  1  one-cycle pulse in DONE after RTI
- done  out  1  one-cycle pulse in DONE for every op

## Operation
- States: IDLE, PUSH, POP_REQ, POP_WAIT, DONE. A 2-bit word index counts the words of the current op.
- Accept: latch op_code, push_pc, push_flags. Index ← 0. CALL/INT → PUSH; RET/RTI → POP_REQ.
- Push order:
  - CALL: PC[31:16], then PC[15:0].
  - INT: PC[31:16], then PC[15:0], then {13'b0, flags}.
- Pop order:
  - RET: PC[15:0], then PC[31:16].
  - RTI: flags (rdata[2:0]), then PC[15:0], then PC[31:16].
- PUSH: mem_req=1, mem_we=1, mem_addr=SP, mem_wdata=current word.
  - On gnt edge: SP ← SP−1 and index+1.
  - After the last word, go to DONE.
- POP_REQ: mem_req=1, mem_we=0, mem_addr=SP+1.
  - On gnt edge: SP ← SP+1 and go to POP_WAIT.
- POP_WAIT: mem_req=0. Capture mem_rdata into the pc_out half or flags_out selected by index; index+1.
  - Go to POP_REQ if words remain, else DONE.
- DONE: assert done; also pc_valid for RET/RTI and flags_valid for RTI. Next state IDLE.
- IDLE: mem_req=0, mem_we=0, mem_addr=SP, mem_wdata=0.
- SP arithmetic is modulo 2^32.
  - Push at SP=0 writes address 0; SP becomes FFFF_FFFF.
  - Pop at SP=FFFF_FFFF reads address 0; SP becomes 0.
- op_valid while busy is ignored; no queueing.
- mem_gnt outside PUSH/POP_REQ is ignored.
- pc_out/flags_out update word-by-word during pops. Consumers use them only on the pc_valid/flags_valid pulse.

## Timing
- Reset (async, reset=0) values:
  - state IDLE, SP=SP_RESET, index 0
  - op_ready=1, stall=0, mem_req=0, mem_we=0, mem_addr=SP_RESET, mem_wdata=0
  - pc_out=0, flags_out=0, all pulses 0
- Reset asserted mid-op aborts the op immediately. Any partially pushed words stay in memory; the SP restore is intentional.
- Latency with mem_gnt tied high, accept edge = cycle 0:
  - CALL: pushes in cycles 1–2, DONE cycle 3, op_ready high cycle 4.
  - INT: pushes 1–3, DONE 4.
  - RET: req/wait pairs in 1–4, DONE 5.
  - RTI: pairs in 1–6, DONE 7.
- Each cycle mem_gnt is low in PUSH/POP_REQ adds one cycle. The request holds stable (addr, we, wdata unchanged) until granted.
- stall rises the cycle after accept and falls the cycle after DONE.
- Outputs other than mem_addr/mem_wdata/mem_req/mem_we/op_ready/stall are registered.

## Test plan
- Reset with SP_RESET=0FFF, then CALL push_pc=0001_2345, gnt=1 → writes (0FFF,0001), (0FFE,2345); SP=0FFD; done pulse at cycle 3.
- Following RET, memory returning the stored words → reads 0FFE then 0FFF; pc_out=0001_2345; pc_valid at cycle 5; SP=0FFF.
- INT with push_pc=0000_00A0, flags=3'b101, then RTI → third write (0FFD,0005); RTI gives flags_out=101, pc_out=0000_00A0, both valid pulses in the same cycle; SP back to 0FFF.
- CALL with gnt low for 3 cycles on the first word → mem_addr/mem_wdata hold 0FFF/0001 throughout; done delayed by exactly 3 cycles; stall high the whole time.
- Wrap: SP_RESET=0, CALL → writes addresses 0 and FFFF_FFFF; SP=FFFF_FFFE; RET restores SP=0.
- Assert reset in the second PUSH cycle of an INT → next sample: state IDLE, SP=SP_RESET, mem_req=0, stall=0, no done pulse.
